// File: rtl/image_uart_sender.sv
// Streams a 1-bpp image from synchronous-read memory to uart_tx, 8 pixels per byte, LSB first.
// Optional trailing XOR checksum byte: define IMG_SENDER_CHECKSUM_EN.
module image_uart_sender #(
  parameter int unsigned NUM_BITS = 784,
  parameter int unsigned ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_q,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_rdy,
  output logic              busy,
  output logic              done
);

  localparam int unsigned NUM_BYTES = NUM_BITS / 8;
`ifdef IMG_SENDER_CHECKSUM_EN
  localparam int unsigned TOTAL_BYTES = NUM_BYTES + 1;
`else
  localparam int unsigned TOTAL_BYTES = NUM_BYTES;
`endif
  localparam int unsigned CNT_W   = $clog2(NUM_BYTES + 2);
  localparam int unsigned PHASE_W = 4;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_WAIT_TX = 3'd2;
  localparam logic [2:0] S_SEND    = 3'd3;
  localparam logic [2:0] S_GAP     = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(8);

  logic [2:0]         state, state_d;
  logic [PHASE_W-1:0] phase, phase_d;
  logic [CNT_W-1:0]   byte_cnt, byte_cnt_d, cnt_inc;
  logic [ADDR_W-1:0]  mem_addr_d;
  logic [7:0]         shift, shift_d;
  logic [7:0]         tx_data_d;
`ifdef IMG_SENDER_CHECKSUM_EN
  logic [7:0]         csum, csum_d;
`endif

  assign cnt_inc = byte_cnt + CNT_W'(1);

  // Next-state and datapath decode
  always_comb begin
    state_d    = state;
    phase_d    = phase;
    byte_cnt_d = byte_cnt;
    mem_addr_d = mem_addr;
    shift_d    = shift;
    tx_data_d  = tx_data;
`ifdef IMG_SENDER_CHECKSUM_EN
    csum_d     = csum;
`endif
    case (state)
      S_IDLE: begin
        if (start) begin
          state_d    = S_FETCH;
          phase_d    = '0;
          byte_cnt_d = '0;
          mem_addr_d = '0;
`ifdef IMG_SENDER_CHECKSUM_EN
          csum_d     = '0;
`endif
        end
      end
      S_FETCH: begin
        // Data for the address issued last phase arrives now; shifting right lands pixel 0 in bit 0.
        if (phase != '0) shift_d = {mem_q, shift[7:1]};
        if (phase == PHASE_LAST) begin
          phase_d = '0;
          state_d = S_WAIT_TX;
        end else begin
          phase_d    = phase + PHASE_W'(1);
          mem_addr_d = mem_addr + ADDR_W'(1);
        end
      end
      S_WAIT_TX: begin
        if (tx_rdy) begin
          state_d = S_SEND;
`ifdef IMG_SENDER_CHECKSUM_EN
          if (byte_cnt == CNT_W'(NUM_BYTES)) begin
            tx_data_d = csum;
          end else begin
            tx_data_d = shift;
            csum_d    = csum ^ shift;
          end
`else
          tx_data_d = shift;
`endif
        end
      end
      S_SEND: state_d = S_GAP;
      S_GAP: begin
        byte_cnt_d = cnt_inc;
        if (cnt_inc == CNT_W'(TOTAL_BYTES)) begin
          state_d = S_DONE;
`ifdef IMG_SENDER_CHECKSUM_EN
        end else if (cnt_inc == CNT_W'(NUM_BYTES)) begin
          state_d = S_WAIT_TX;
`endif
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      phase    <= '0;
      byte_cnt <= '0;
      mem_addr <= '0;
      shift    <= '0;
      tx_data  <= '0;
      tx_start <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef IMG_SENDER_CHECKSUM_EN
      csum     <= '0;
`endif
    end else begin
      state    <= state_d;
      phase    <= phase_d;
      byte_cnt <= byte_cnt_d;
      mem_addr <= mem_addr_d;
      shift    <= shift_d;
      tx_data  <= tx_data_d;
      tx_start <= (state_d == S_SEND);
      busy     <= (state_d != S_IDLE) && (state_d != S_DONE);
      done     <= (state_d == S_DONE);
`ifdef IMG_SENDER_CHECKSUM_EN
      csum     <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_image_uart_sender.sv
// Directed bench for image_uart_sender: byte packing, timing, tx_rdy handshake, start/rst handling.
// Honours IMG_SENDER_CHECKSUM_EN for the expected byte count and trailing checksum.
module tb_image_uart_sender;

  localparam int unsigned NUM_BITS = 784;
  localparam int unsigned ADDR_W   = 10;
  localparam int unsigned NB       = NUM_BITS / 8;
  localparam int unsigned LOW      = 40;
`ifdef IMG_SENDER_CHECKSUM_EN
  localparam int unsigned NTX = NB + 1;
`else
  localparam int unsigned NTX = NB;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              mem_q = 1'b0;
  logic [ADDR_W-1:0] mem_addr;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_rdy;
  logic              busy;
  logic              done;

  logic              mem [0:1023];
  logic              slow = 1'b0;
  int unsigned       low_cnt = 0;
  int unsigned       cycle = 0;
  int                n_cmp = 0;
  int                n_err = 0;
  logic [7:0]        got[$];
  logic [7:0]        last_tx = 8'h00;
  logic [7:0]        pat [0:NB-1];
  int                done_cnt = 0;
  int                busy_cnt = 0;
  int                first_tx = -1;
  int unsigned       t0 = 0;
  int unsigned       td = 0;

  image_uart_sender #(.NUM_BITS(NUM_BITS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .mem_addr(mem_addr), .mem_q(mem_q),
    .tx_start(tx_start), .tx_data(tx_data), .tx_rdy(tx_rdy), .busy(busy), .done(done)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;
  always @(posedge clk) mem_q <= mem[mem_addr];

  // Transmitter model: busy for LOW cycles after each launch when slow
  always @(posedge clk) begin
    if (rst) low_cnt <= 0;
    else if (slow && tx_start) low_cnt <= LOW;
    else if (low_cnt != 0) low_cnt <= low_cnt - 1;
  end
  assign tx_rdy = (low_cnt == 0);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (slow && low_cnt != 0) begin
      check("no_start_while_not_rdy", 32'(tx_start), 32'd0);
      check("tx_data_stable", 32'(tx_data), 32'(last_tx));
    end
    if (tx_start) begin
      got.push_back(tx_data);
      last_tx = tx_data;
      if (first_tx < 0) first_tx = int'(cycle);
    end
    if (done) done_cnt++;
    if (busy) busy_cnt++;
  end

  task automatic start_run();
    got.delete();
    done_cnt = 0;
    busy_cnt = 0;
    first_tx = -1;
    t0 = cycle;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    int n = 0;
    while (done !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    td = cycle;
    check(tag, 32'(done === 1'b1), 32'd1);
  endtask

  task automatic wait_bytes(input string tag, input int count, input int limit);
    int n = 0;
    while (got.size() < count && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(got.size() >= count), 32'd1);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = 1'b0;
  endtask

  initial begin
    logic [7:0] acc;
    logic [7:0] cs;
    int         n_before;

    for (int i = 0; i < 1024; i++) mem[i] = 1'b1;
    for (int k = 0; k < int'(NB); k++) pat[k] = 8'(k * 37 + 5);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // All-ones image, tx_rdy always high
    start_run();
    check("t1_busy_c1", 32'(busy), 32'd1);
    check("t1_addr_c1", 32'(mem_addr), 32'd0);
    wait_done("t1_done_seen", 5000);
    check("t1_done_cycle", td - t0, 32'd1177 + 32'(NTX - NB) * 32'd3);
    check("t1_first_tx_cycle", 32'(first_tx) - t0, 32'd11);
    repeat (4) @(negedge clk);
    check("t1_done_count", 32'(done_cnt), 32'd1);
    check("t1_busy_cycles", 32'(busy_cnt), 32'd1176 + 32'(NTX - NB) * 32'd3);
    check("t1_nbytes", 32'(got.size()), 32'(NTX));
    for (int k = 0; k < int'(NB) && k < got.size(); k++) check("t1_byte_ff", 32'(got[k]), 32'hFF);
`ifdef IMG_SENDER_CHECKSUM_EN
    if (got.size() == NTX) check("t1_csum", 32'(got[NB]), 32'h00);
`endif

    // Bit ordering: pixels 0 and 15 only
    clear_mem();
    mem[0]  = 1'b1;
    mem[15] = 1'b1;
    start_run();
    wait_done("t2_done_seen", 5000);
    repeat (2) @(negedge clk);
    check("t2_nbytes", 32'(got.size()), 32'(NTX));
    acc = 8'h00;
    for (int k = 2; k < int'(NB) && k < got.size(); k++) acc = acc | got[k];
    if (got.size() >= 2) begin
      check("t2_byte0", 32'(got[0]), 32'h01);
      check("t2_byte1", 32'(got[1]), 32'h80);
    end
    check("t2_rest_zero", 32'(acc), 32'h00);

    // Slow transmitter with a stray start during byte 40
    for (int k = 0; k < int'(NB); k++)
      for (int i = 0; i < 8; i++) mem[8*k + i] = pat[k][i];
    slow = 1'b1;
    start_run();
    wait_bytes("t3_reach_byte40", 40, 8000);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t3_busy_after_start", 32'(busy), 32'd1);
    wait_done("t3_done_seen", 20000);
    while (low_cnt != 0) @(negedge clk);
    repeat (3) @(negedge clk);
    slow = 1'b0;
    check("t3_nbytes", 32'(got.size()), 32'(NTX));
    check("t3_done_count", 32'(done_cnt), 32'd1);
    cs = 8'h00;
    for (int k = 0; k < int'(NB) && k < got.size(); k++) begin
      check("t3_byte", 32'(got[k]), 32'(pat[k]));
      cs = cs ^ pat[k];
    end
`ifdef IMG_SENDER_CHECKSUM_EN
    if (got.size() == NTX) check("t3_csum", 32'(got[NB]), 32'(cs));
`endif
    check("t3_idle_busy", 32'(busy), 32'd0);

    // Reset during FETCH of byte 10, then restart from byte 0
    start_run();
    wait_bytes("t5_reach_byte10", 10, 2000);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_busy_after_rst", 32'(busy), 32'd0);
    check("t5_tx_start_after_rst", 32'(tx_start), 32'd0);
    check("t5_addr_after_rst", 32'(mem_addr), 32'd0);
    check("t5_tx_data_after_rst", 32'(tx_data), 32'd0);
    n_before = got.size();
    repeat (30) @(negedge clk);
    check("t5_no_more_bytes", 32'(got.size()), 32'(n_before));
    check("t5_idle_busy", 32'(busy), 32'd0);

    // rst wins over start in the same cycle
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("t5_rst_beats_start", 32'(busy), 32'd0);

    start_run();
    check("t5_restart_busy", 32'(busy), 32'd1);
    check("t5_restart_addr", 32'(mem_addr), 32'd0);
    wait_done("t5_done_seen", 5000);
    repeat (2) @(negedge clk);
    check("t5_nbytes", 32'(got.size()), 32'(NTX));
    if (got.size() >= 1) check("t5_byte0", 32'(got[0]), 32'(pat[0]));

    // Bytes 0x01, 0x03, rest zero: checksum byte would be 0x02
    clear_mem();
    mem[0] = 1'b1;
    mem[8] = 1'b1;
    mem[9] = 1'b1;
    start_run();
    wait_done("t6_done_seen", 5000);
    repeat (3) @(negedge clk);
    check("t6_nbytes", 32'(got.size()), 32'(NTX));
    check("t6_done_count", 32'(done_cnt), 32'd1);
    if (got.size() >= 2) begin
      check("t6_byte0", 32'(got[0]), 32'h01);
      check("t6_byte1", 32'(got[1]), 32'h03);
    end
`ifdef IMG_SENDER_CHECKSUM_EN
    if (got.size() == NTX) check("t6_csum", 32'(got[NB]), 32'h02);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
